buffer_read_controller: RTL and testbench



---
 rtl/buffer_read_controller.sv | 143 ++++++++++++++
 tb/tb_buffer_read_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_read_controller.sv
// Drains a fixed-length burst from a PE scratchpad FIFO into the MAC datapath via a 2-entry staging buffer.
// Latency: first out_valid 2 cycles after the edge that accepts start; then 1 word/cycle sustained.
// Backpressure: pops stop when staged + in-flight words would exceed 2; optional stall counter under BUF_RD_PERF_EN.
module buffer_read_controller #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef BUF_RD_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued_q;
  logic [LEN_W-1:0]   delivered_q;
  logic               accept;

  logic [DATA_W-1:0]  stg_q [2];
  logic               hd_q, tl_q;
  logic [1:0]         occ_q;
  logic               inflight_q;
  logic               out_pop;
  logic [1:0]         used;

  assign out_pop   = out_valid & out_ready;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = stg_q[hd_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // A word leaving downstream this cycle frees its slot before the next capture,
  // so it is credited back; otherwise a steady stream would stall every other cycle.
  assign used = occ_q + {1'b0, inflight_q} - {1'b0, out_pop};

  // State register; holds while en is low
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, pop strobe and start acceptance
  always_comb begin
    state_d  = state_q;
    fifo_ren = 1'b0;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && start) begin
          accept  = 1'b1;
          state_d = (burst_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        fifo_ren = en & ~fifo_empty & (issued_q < len_q) & (used < 2'd2);
        if (en && issued_q == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (en && delivered_q == len_q && occ_q == 2'd0) state_d = S_DONE;
      end
      S_DONE: begin
        if (en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst length latch and issued/delivered counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
    end else if (accept) begin
      len_q       <= burst_len;
      issued_q    <= '0;
      delivered_q <= '0;
    end else begin
      if (fifo_ren) issued_q    <= issued_q + LEN_W'(1);
      if (out_pop)  delivered_q <= delivered_q + LEN_W'(1);
    end
  end

  // Read-latency tracking and staging buffer; runs regardless of en so in-flight data lands
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= 1'b0;
      stg_q[0]   <= '0;
      stg_q[1]   <= '0;
      hd_q       <= 1'b0;
      tl_q       <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      inflight_q <= fifo_ren;
      if (inflight_q) begin
        stg_q[tl_q] <= fifo_rdata;
        tl_q        <= ~tl_q;
      end
      if (out_pop) hd_q <= ~hd_q;
      case ({inflight_q, out_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef BUF_RD_PERF_EN
  // Saturating count of cycles the fetch stage waited on an empty FIFO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= 16'd0;
    end else if (accept) begin
      stall_cnt <= 16'd0;
    end else if (state_q == S_FETCH && en && fifo_empty && issued_q < len_q &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_buffer_read_controller.sv
`timescale 1ns/1ps
module tb_buffer_read_controller;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  localparam int DC     = -99;

  logic              clk = 1'b0;
  logic              rstn, en, start, fifo_empty, fifo_ren;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] fifo_rdata, out_data;
  logic              out_valid, out_ready, busy, done;
`ifdef BUF_RD_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  buffer_read_controller #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
`ifdef BUF_RD_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Burst descriptor: windows are absolute cycle ranges (c=0 is the start cycle),
  // percentages give random availability outside them; DC = don't care.
  typedef struct {
    int len;
    int r_a, r_b;      // out_ready forced low
    int e_a, e_b;      // FIFO forced empty
    int n_a, n_b;      // en forced low
    int r_pct, a_pct, n_pct;
    int exp_fv;        // cycle of first out_valid (-1 = never)
    int exp_done;      // cycle of done pulse
    int exp_stall;     // stall_cnt at burst end
  } vec_t;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [DATA_W-1:0] src_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected output stream is simply the first len words placed in the FIFO, in order.
  task automatic run_burst(input vec_t v);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] w;
    int dlv, ndone, fv, done_c, pops0, c, outstanding;
    bit finished, in_r, in_e, in_n, avail, rs;
    src_q.delete();
    for (int i = 0; i < v.len + 3; i++) begin
      w = DATA_W'($urandom);
      src_q.push_back(w);
      if (i < v.len) exp_q.push_back(w);
    end
    dlv = 0; ndone = 0; fv = -1; done_c = -1; pops0 = pops; finished = 0;
    for (c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      in_r = (c >= v.r_a && c <= v.r_b);
      in_e = (c >= v.e_a && c <= v.e_b);
      in_n = (c >= v.n_a && c <= v.n_b);
      start     = (c == 0);
      burst_len = (c == 0) ? LEN_W'(v.len) : LEN_W'($urandom);
      en        = (c == 0) || (dlv >= v.len) || (!in_n && ($urandom_range(99) < v.n_pct));
      out_ready = !in_r && ($urandom_range(99) < v.r_pct);
      avail     = !in_e && ($urandom_range(99) < v.a_pct);
      fifo_empty = (src_q.size() == 0) || !avail;
      #1;
      rs = fifo_ren;
      if (!en) chk("ren_while_disabled", {31'd0, fifo_ren}, 32'd0);
      outstanding = pops - pops0 - dlv;
      chk("outstanding_le2", {31'd0, (outstanding <= 2)}, 32'd1);
      if (out_valid && fv < 0) fv = c;
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) chk("data_order", out_data, exp_q.pop_front());
        else chk("extra_word", dlv + 1, v.len);
        dlv++;
      end
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        finished = 1;
      end
      @(posedge clk);
      #1;
      if (rs) begin
        fifo_rdata = src_q.pop_front();
        pops++;
      end
    end
    if (!finished) begin
      errors++;
      checks++;
      $display("FAIL burst_timeout len=%0d delivered=%0d", v.len, dlv);
    end
    chk("words_delivered", dlv, v.len);
    chk("done_pulses", ndone, 1);
    chk("fifo_pops", pops - pops0, v.len);
    if (v.exp_fv != DC)   chk("first_valid_cycle", fv, v.exp_fv);
    if (v.exp_done != DC) chk("done_cycle", done_c, v.exp_done);
`ifdef BUF_RD_PERF_EN
    if (v.exp_stall != DC) chk("stall_cnt", {16'd0, stall_cnt}, v.exp_stall);
`endif
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    int dl;
    bit rs;
    tbl[0] = '{4,   -1, -1, -1, -1, -1, -1, 100, 100, 100, 3,  8,   0};   // full burst
    tbl[1] = '{6,    3,  7, -1, -1, -1, -1, 100, 100, 100, 3,  DC,  0};   // backpressure
    tbl[2] = '{8,   -1, -1,  3,  7, -1, -1, 100, 100, 100, 3,  DC,  5};   // underrun
    tbl[3] = '{0,   -1, -1, -1, -1, -1, -1, 100, 100, 100, -1, 1,   0};   // zero length
    tbl[4] = '{6,   -1, -1, -1, -1,  3,  5, 100, 100, 100, 3,  DC,  0};   // enable freeze
    tbl[5] = '{255, -1, -1, -1, -1, -1, -1, 100, 100, 100, 3,  259, 0};   // maximum burst
    tbl[6] = '{1,   -1, -1, -1, -1, -1, -1, 100, 100, 100, 3,  5,   0};   // single word

    rstn = 1'b0; en = 1'b1; start = 1'b0; burst_len = '0;
    out_ready = 1'b1; fifo_empty = 1'b0; fifo_rdata = '0;
    #1;
    chk("rst_fifo_ren", {31'd0, fifo_ren}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
`ifdef BUF_RD_PERF_EN
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_burst(tbl[i]);

    // Mid-burst reset: deliver 2 of 5 words, then pull rstn low asynchronously.
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(DATA_W'(16'h0100 + i));
    dl = 0;
    for (int c = 0; c < 40 && dl < 2; c++) begin
      @(negedge clk);
      start = (c == 0); burst_len = LEN_W'(5); en = 1'b1; out_ready = 1'b1;
      fifo_empty = (src_q.size() == 0);
      #1;
      rs = fifo_ren;
      if (out_valid && out_ready) dl++;
      @(posedge clk);
      #1;
      if (rs) begin
        fifo_rdata = src_q.pop_front();
        pops++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("pre_rst_delivered", dl, 2);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_fifo_ren", {31'd0, fifo_ren}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    rv = '{3, -1, -1, -1, -1, -1, -1, 100, 100, 100, 3, 7, 0};
    run_burst(rv);

    // Randomized bursts with random backpressure, underruns and enable gaps.
    for (int i = 0; i < 25; i++) begin
      rv = '{int'($urandom_range(0, 20)), -1, -1, -1, -1, -1, -1,
             int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
             int'($urandom_range(50, 100)), DC, DC, DC};
      run_burst(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
